// File: rtl/stack_pkg.sv
// Shared types and constants for the memory-mapped LIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stack_pkg;

  // Controller states: IDLE accepts requests, REFILL waits on the RAM read.
  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } stateT;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVF  = 0;
  localparam int ERR_UNF  = 1;
  localparam int ERR_BUSY = 2;

  // Default geometry, matching the MEM bus word.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 256;

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM holding every stack entry below the top.
// Latency: write takes effect on the edge; read data is registered, valid one cycle after readEn.
// Backpressure: none; the caller never issues a read and a write in the same cycle.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             writeEn,
  input  logic             readEn,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData
);

  // The top entry lives in a register outside, so only DEPTH-1 words are needed.
  logic [WIDTH-1:0] mem [0:DEPTH-2];

  // Plain write / registered read with no reset so the array maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (writeEn) begin
      mem[addr] <= wrData;
    end
    if (readEn) begin
      rdData <= mem[addr];
    end
  end

endmodule

// File: rtl/mmio_stack.sv
// Memory-mapped LIFO: write pushes, read pops, write+read replaces the top entry.
// Latency: push/replace 1 cycle; pop with >=2 entries takes 2 cycles (RAM refill).
// Backpressure: ready drops for the single REFILL cycle; requests arriving then are dropped and flagged.
module mmio_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sel,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             ready,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic [2:0]       err
);

  localparam int AW = $clog2(DEPTH);

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] tosNext;
  logic [CW-1:0]    countNext;
  logic [2:0]       errSet;
  logic [2:0]       errNext;

  logic             ramWe;
  logic             ramRe;
  logic [AW-1:0]    ramAddr;
  logic [WIDTH-1:0] ramRdata;

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uRam (
    .CLK     (CLK),
    .writeEn (ramWe),
    .readEn  (ramRe),
    .addr    (ramAddr),
    .wrData  (tos),
    .rdData  (ramRdata)
  );

  // Decode the bus request against the current state; RAM is touched only on push-with-data and deep pop.
  always_comb begin
    stateNext = state;
    tosNext   = tos;
    countNext = count;
    errSet    = '0;
    ramWe     = 1'b0;
    ramRe     = 1'b0;
    ramAddr   = '0;
    case (state)
      IDLE: begin
        if (sel && write && !read) begin
          if (count < CW'(DEPTH)) begin
            if (count != '0) begin
              // Old top slides down into the slot just above the last RAM entry.
              ramWe   = 1'b1;
              ramAddr = AW'(count - CW'(1));
            end
            tosNext   = din;
            countNext = count + CW'(1);
          end else begin
            errSet[ERR_OVF] = 1'b1;
          end
        end else if (sel && read && !write) begin
          if (count == '0) begin
            errSet[ERR_UNF] = 1'b1;
          end else if (count == CW'(1)) begin
            tosNext   = '0;
            countNext = '0;
          end else begin
            // Fetch the entry below the top; it lands in TOS during REFILL.
            ramRe     = 1'b1;
            ramAddr   = AW'(count - CW'(2));
            countNext = count - CW'(1);
            stateNext = REFILL;
          end
        end else if (sel && write && read) begin
          tosNext = din;
          if (count == '0) begin
            countNext = CW'(1);
          end
        end
      end
      REFILL: begin
        tosNext   = ramRdata;
        stateNext = IDLE;
        if (sel && (write || read)) begin
          errSet[ERR_BUSY] = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    // A fresh error in the same cycle as clr_err must survive the clear.
    errNext = (clr_err ? 3'b000 : err) | errSet;
  end

  // Controller state register; reset abandons any in-flight refill.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Top-of-stack, occupancy and sticky error registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tos   <= '0;
      count <= '0;
      err   <= '0;
    end else begin
      tos   <= tosNext;
      count <= countNext;
      err   <= errNext;
    end
  end

  assign dout  = tos;
  assign ready = (state == IDLE);
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_mmio_stack.sv
// Directed bench for mmio_stack with a DEPTH=4 instance and a queue-based scoreboard.
// Latency: each stimulus cycle queues the state expected after the following clock edge.
// Backpressure: REFILL cycles are exercised, including a request dropped while busy.
module tb_mmio_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             CLK;
  logic             RST;
  logic             sel;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             ready;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic [2:0]       err;

  typedef struct packed {
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             ready;
    logic             empty;
    logic             full;
    logic [2:0]       err;
  } expT;

  expT   expQ[$];
  string nameQ[$];
  int    total = 0;
  int    bad   = 0;
  event  sampleEv;

  mmio_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .sel     (sel),
    .write   (write),
    .read    (read),
    .din     (din),
    .clr_err (clr_err),
    .dout    (dout),
    .ready   (ready),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .err     (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Queue the expected visible state; empty/full follow directly from the expected count.
  task automatic expect_state(input logic [WIDTH-1:0] eDout, input logic [CW-1:0] eCnt,
                              input logic [2:0] eErr, input logic eRdy, input string nm);
    expT e;
    e.dout  = eDout;
    e.count = eCnt;
    e.ready = eRdy;
    e.empty = (eCnt == 0);
    e.full  = (eCnt == CW'(DEPTH));
    e.err   = eErr;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  // Drive one cycle of bus activity just after the falling edge and queue the post-edge result.
  task automatic step(input logic s, input logic w, input logic r, input logic [WIDTH-1:0] d,
                      input logic c, input logic [WIDTH-1:0] eDout, input logic [CW-1:0] eCnt,
                      input logic [2:0] eErr, input logic eRdy, input string nm);
    @(negedge CLK);
    #1;
    sel     = s;
    write   = w;
    read    = r;
    din     = d;
    clr_err = c;
    expect_state(eDout, eCnt, eErr, eRdy, nm);
  endtask

  // Monitor: each falling edge (or explicit sample request) retires the oldest expectation.
  initial begin
    expT e;
    expT a;
    string nm;
    forever begin
      @(negedge CLK or sampleEv);
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        a.dout  = dout;
        a.count = count;
        a.ready = ready;
        a.empty = empty;
        a.full  = full;
        a.err   = err;
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got dout=%h count=%0d ready=%b empty=%b full=%b err=%b, want dout=%h count=%0d ready=%b empty=%b full=%b err=%b",
                   nm, a.dout, a.count, a.ready, a.empty, a.full, a.err,
                   e.dout, e.count, e.ready, e.empty, e.full, e.err);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; sel = 1'b0; write = 1'b0; read = 1'b0; din = '0; clr_err = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;

    //    sel  wr   rd   din       clr   dout      cnt  err     rdy
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'b000, 1'b1, "reset_idle");
    step(1'b1, 1'b1, 1'b0, 16'h1111, 1'b0, 16'h1111, 3'd1, 3'b000, 1'b1, "push_1111");
    step(1'b1, 1'b1, 1'b0, 16'h2222, 1'b0, 16'h2222, 3'd2, 3'b000, 1'b1, "push_2222");
    step(1'b1, 1'b1, 1'b0, 16'h3333, 1'b0, 16'h3333, 3'd3, 3'b000, 1'b1, "push_3333");
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h3333, 3'd2, 3'b000, 1'b0, "pop3_refill");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h2222, 3'd2, 3'b000, 1'b1, "pop3_done");
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h2222, 3'd1, 3'b000, 1'b0, "pop2_refill");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1111, 3'd1, 3'b000, 1'b1, "pop2_done");
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'b000, 1'b1, "pop_last");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'b000, 1'b1, "empty_idle");
    // Fill to capacity, then overflow.
    step(1'b1, 1'b1, 1'b0, 16'h00A0, 1'b0, 16'h00A0, 3'd1, 3'b000, 1'b1, "fill_a0");
    step(1'b1, 1'b1, 1'b0, 16'h00A1, 1'b0, 16'h00A1, 3'd2, 3'b000, 1'b1, "fill_a1");
    step(1'b1, 1'b1, 1'b0, 16'h00A2, 1'b0, 16'h00A2, 3'd3, 3'b000, 1'b1, "fill_a2");
    step(1'b1, 1'b1, 1'b0, 16'h00A3, 1'b0, 16'h00A3, 3'd4, 3'b000, 1'b1, "fill_a3");
    step(1'b1, 1'b1, 1'b0, 16'h00FF, 1'b0, 16'h00A3, 3'd4, 3'b001, 1'b1, "overflow");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00A3, 3'd4, 3'b000, 1'b1, "clr_ovf");
    step(1'b1, 1'b1, 1'b0, 16'h00FF, 1'b1, 16'h00A3, 3'd4, 3'b001, 1'b1, "set_beats_clr");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00A3, 3'd4, 3'b000, 1'b1, "clr_again");
    step(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 16'h00A3, 3'd4, 3'b000, 1'b1, "sel_low");
    // Drain from full, checking each RAM level.
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h00A3, 3'd3, 3'b000, 1'b0, "drain4_refill");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00A2, 3'd3, 3'b000, 1'b1, "drain4_done");
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h00A2, 3'd2, 3'b000, 1'b0, "drain3_refill");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00A1, 3'd2, 3'b000, 1'b1, "drain3_done");
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h00A1, 3'd1, 3'b000, 1'b0, "drain2_refill");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00A0, 3'd1, 3'b000, 1'b1, "drain2_done");
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'b000, 1'b1, "drain1");
    // Underflow and replace.
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'b010, 1'b1, "underflow");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 3'd0, 3'b000, 1'b1, "clr_unf");
    step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 16'h5555, 3'd1, 3'b000, 1'b1, "replace_empty");
    step(1'b1, 1'b1, 1'b1, 16'h6666, 1'b0, 16'h6666, 3'd1, 3'b000, 1'b1, "replace_one");
    step(1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h1234, 3'd2, 3'b000, 1'b1, "push_1234");
    // Request during REFILL is dropped.
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1234, 3'd1, 3'b000, 1'b0, "pop_before_busy");
    step(1'b1, 1'b1, 1'b0, 16'h7777, 1'b0, 16'h6666, 3'd1, 3'b100, 1'b1, "busy_drop");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h6666, 3'd1, 3'b100, 1'b1, "busy_hold");
    // Async reset in the middle of a REFILL.
    step(1'b1, 1'b1, 1'b0, 16'h8888, 1'b0, 16'h8888, 3'd2, 3'b100, 1'b1, "push_8888");
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h8888, 3'd1, 3'b100, 1'b0, "pop_into_rst");
    @(negedge CLK);
    #2;
    sel = 1'b0; write = 1'b0; read = 1'b0; clr_err = 1'b0;
    RST = 1'b1;
    #1;
    expect_state(16'h0000, 3'd0, 3'b000, 1'b1, "async_reset");
    ->sampleEv;
    #1 RST = 1'b0;
    step(1'b1, 1'b1, 1'b0, 16'h0042, 1'b0, 16'h0042, 3'd1, 3'b000, 1'b1, "push_after_rst");
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0042, 3'd1, 3'b000, 1'b1, "hold_after_rst");

    // Bounded drain of the scoreboard.
    repeat (3) @(negedge CLK);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_stack.md
Name: mmio_stack

Overview:
- Memory-mapped hardware LIFO. It is the responder behind the MEM-bus select lines `addrstack` and `userstack`; one instance is placed per select.
- The CPU pushes a word by writing to the stack's MEM address and pops one by reading it.
- The top of stack sits in a register so reads see it with zero wait. Words below the top live in an inferred synchronous block RAM.
- Status (count, sticky error flags) is exported for the MEM status word.

Parameters:
- WIDTH, 16, data word width; matches the MEM bus.
- DEPTH, 256, maximum number of entries including the top-of-stack register; must be a power of 2 and ≥ 2.
- CW, $clog2(DEPTH)+1, width of the count output.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- sel  in  1  address-decode select for this stack (MEM bus strobe).
- write  in  1  MEM write qualifier; push when sel&write.
- read  in  1  single-cycle pop pulse; pop when sel&read.
- din  in  WIDTH  write data from the MEM bus.
- clr_err  in  1  clears the sticky error flags.
- dout  out  WIDTH  current top of stack; 0 when empty.
- ready  out  1  high when a request is accepted this cycle.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  CW  number of stored entries.
- err  out  3  sticky flags {busy_drop, underflow, overflow}.

Behaviour:
- Reset (async, RST=1) sets: count=0, dout=0, state IDLE, ready=1, empty=1, full=0, err=0. RAM contents are don't-care.
- Storage layout: the top entry is held in register TOS, which drives dout. Entries 0..count-2 are held in RAM, with RAM[count-2] directly below the top.
- FSM states: IDLE, REFILL. ready = (state==IDLE).
- IDLE, push only (sel&write&!read):
  - If count<DEPTH: when count>0, RAM[count-1]<=TOS; then TOS<=din; count++.
  - Takes one cycle; dout shows din on the next edge; state stays IDLE.
  - If full: the request is ignored and err.overflow<=1.
- IDLE, pop (sel&read&!write):
  - count==0: ignored, dout stays 0, err.underflow<=1.
  - count==1: TOS<=0, count<=0, stay IDLE.
  - count≥2: issue RAM read at count-2, count--, go to REFILL.
- REFILL: TOS<=RAM read data; return to IDLE. Pop latency is therefore 2 cycles, and ready is low for exactly one cycle.
- IDLE, replace (sel&write&read): TOS<=din, count unchanged, no RAM access. If count==0 it behaves as a push (count=1).
- Any sel&(write|read) while in REFILL is dropped and sets err.busy_drop<=1. State is not otherwise disturbed.
- sel low: write and read are ignored.
- clr_err is synchronous and clears all err bits. If clr_err coincides with a new error event, the set wins.
- count never wraps; it saturates at 0 and DEPTH via the guards above.
- RST during REFILL: state returns to IDLE and count=0 immediately. The in-flight RAM read is discarded.
- All outputs are registered or derived directly from registers (count, state); there is no combinational path from din to dout.

Decomposition:
- Package stack_pkg:
  - state enum (IDLE, REFILL);
  - err bit indices ERR_OVF=0, ERR_UNF=1, ERR_BUSY=2;
  - default WIDTH and DEPTH constants.
- Sub-module stack_ram: single-port synchronous RAM, DEPTH-1 words × WIDTH, with write enable, one-cycle registered read, and no reset. It is kept separate so block-RAM inference can be checked in isolation.

Test Plan:
- Reset then idle → dout=0, count=0, empty=1, ready=1, err=0.
- Push 0x1111, 0x2222, 0x3333 on consecutive cycles → dout=0x3333, count=3. Pop → ready=0 for 1 cycle, then dout=0x2222, count=2. Pop, pop → dout=0x1111, then 0, empty=1.
- Fill DEPTH=4 instance with 0xA0..0xA3, then push 0xFF → full=1, count=4, dout=0xA3, err=3'b001. Pulse clr_err → err=0.
- Pop on empty → err=3'b010, dout=0, count=0. Replace with 0x5555 on empty → count=1, dout=0x5555.
- With count=2, pop then push 0x7777 on the following (REFILL) cycle → push dropped, err=3'b100, dout=old second entry, count=1.
- Assert RST asynchronously mid-REFILL (between clock edges) → outputs return to reset values before the next CLK edge. A subsequent push of 0x0042 gives dout=0x0042, count=1.
